// File: rtl/booth_mul_requester.sv
// booth_mul_requester: buffers operand pairs, issues them one at a time to the Booth multiplier and forwards each product downstream.
// Define BOOTH_MUL_CHECK_EN to compare every captured product against a reference multiply (out_err + $error).
module booth_mul_requester #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_val,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               src_val,
  input  logic               src_ready,
  output logic [WIDTH-1:0]   mcand,
  output logic [WIDTH-1:0]   mplier,
  input  logic               dest_val,
  output logic               dest_ready,
  input  logic [2*WIDTH-1:0] product,
  output logic               out_val,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_err,
  output logic [15:0]        done_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [2*WIDTH-1:0] out_p_q, out_p_d;
  logic out_err_q, out_err_d;
  logic src_val_q, src_val_d, dest_ready_q, dest_ready_d, out_val_q, out_val_d;
  logic [15:0] done_q, done_d;
  logic push, pop, empty, chk_err;
  assign empty    = cnt_q == '0;
  assign in_ready = cnt_q != FULL;
  assign push     = in_val && in_ready;
  assign pop      = state_q == ISSUE && src_ready;
  assign mcand    = empty ? '0 : mem_a_q[rd_q];
  assign mplier   = empty ? '0 : mem_b_q[rd_q];
`ifdef BOOTH_MUL_CHECK_EN
  logic [2*WIDTH-1:0] ref_p;
  assign ref_p   = {{WIDTH{out_a_q[WIDTH-1]}}, out_a_q} * {{WIDTH{out_b_q[WIDTH-1]}}, out_b_q};
  assign chk_err = product != ref_p;
  always_ff @(posedge clk)
    if (rst && state_q == WAIT && dest_val && chk_err)
      $error("booth_mul_requester: product %h for %h * %h, reference %h", product, out_a_q, out_b_q, ref_p);
`else
  assign chk_err = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    out_p_d   = out_p_q;
    out_err_d = out_err_q;
    done_d    = done_q;
    wr_d      = wr_q + AW'(push);
    rd_d      = rd_q + AW'(pop);
    cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    case (state_q)
      IDLE:  state_d = empty ? IDLE : ISSUE;
      ISSUE: if (src_ready) begin
        state_d = WAIT;
        out_a_d = mcand;
        out_b_d = mplier;
      end
      WAIT:  if (dest_val) begin
        state_d   = HOLD;
        out_p_d   = product;
        out_err_d = chk_err;
      end
      HOLD:  if (out_ready) begin
        done_d  = done_q + 16'd1;
        state_d = (cnt_d != '0) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    src_val_d    = state_d == ISSUE;
    dest_ready_d = state_d == WAIT;
    out_val_d    = state_d == HOLD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= IDLE;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_p_q      <= '0;
      out_err_q    <= 1'b0;
      done_q       <= '0;
      src_val_q    <= 1'b0;
      dest_ready_q <= 1'b0;
      out_val_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_p_q      <= out_p_d;
      out_err_q    <= out_err_d;
      done_q       <= done_d;
      src_val_q    <= src_val_d;
      dest_ready_q <= dest_ready_d;
      out_val_q    <= out_val_d;
    end
  // Storage needs no reset: the occupancy counter alone decides what is valid.
  always_ff @(posedge clk)
    if (push) begin
      mem_a_q[wr_q] <= in_a;
      mem_b_q[wr_q] <= in_b;
    end
  assign src_val    = src_val_q;
  assign dest_ready = dest_ready_q;
  assign out_val    = out_val_q;
  assign out_a      = out_a_q;
  assign out_b      = out_b_q;
  assign out_p      = out_p_q;
  assign out_err    = out_err_q;
  assign done_cnt   = done_q;
endmodule

// File: tb/tb_booth_mul_requester.sv
// tb_booth_mul_requester: directed scoreboard bench with a behavioural multiplier replying 4 cycles after acceptance.
module tb_booth_mul_requester;
  logic clk = 1'b0;
  logic rst, in_val, in_ready, src_val, src_ready, dest_val, dest_ready, out_val, out_ready, out_err;
  logic [15:0] in_a, in_b, mcand, mplier, out_a, out_b, done_cnt;
  logic [31:0] product, out_p;
  typedef struct packed {logic [15:0] a; logic [15:0] b; logic [31:0] p; logic e;} rec_t;
  rec_t exp_q[$];
  rec_t mon_r;
  int n_chk = 0, n_fail = 0, drops = 0;
  logic [15:0] my_done = '0;
  logic [63:0] saved;
  logic seen;
  logic [15:0] va [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000, 16'd0, 16'd100};
  logic [15:0] vb [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'd1234, 16'hFF38};
  logic [31:0] vp [6] = '{32'h1, 32'h3FFF0001, 32'h40000000, 32'hC0008000, 32'h0, 32'hFFFFB1E0};

  booth_mul_requester #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .src_val(src_val), .src_ready(src_ready), .mcand(mcand), .mplier(mplier),
    .dest_val(dest_val), .dest_ready(dest_ready), .product(product),
    .out_val(out_val), .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_p(out_p),
    .out_err(out_err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic rec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p, input logic e);
    rec_t r;
    r.a = a; r.b = b; r.p = p; r.e = e;
    return r;
  endfunction

  function automatic logic [31:0] mul(input logic [15:0] a, input logic [15:0] b);
`ifdef BOOTH_MUL_CHECK_EN
    if (a == 16'd7 && b == 16'd7) return 32'h0;
`endif
    return {{16{a[15]}}, a} * {{16{b[15]}}, b};
  endfunction

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p, input logic e);
    int i;
    in_val = 1'b1; in_a = a; in_b = b;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1;
    in_val = 1'b0;
    if (i == 200) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: in_ready stayed 0 for a=%h, required 1", a);
    end else exp_q.push_back(mk(a, b, p, e));
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  // Behavioural multiplier: product appears 4 edges after the source handshake.
  initial begin
    logic [15:0] ma, mb;
    int k;
    forever begin
      @(negedge clk);
      if (rst && src_val && src_ready) begin
        ma = mcand; mb = mplier;
        repeat (4) @(posedge clk);
        #1;
        dest_val = 1'b1; product = mul(ma, mb);
        for (k = 0; k < 50; k++) begin
          @(negedge clk);
          if (dest_ready) break;
        end
        if (k == 50) drops++;
        @(posedge clk); #1;
        dest_val = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_val && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: got a=%h b=%h p=%h, required no result", out_a, out_b, out_p);
        end else begin
          mon_r = exp_q.pop_front();
          chk("out_record", {out_a, out_b, out_p}, {mon_r.a, mon_r.b, mon_r.p});
          chk("out_err", 64'(out_err), 64'(mon_r.e));
          chk("done_cnt", 64'(done_cnt), 64'(my_done));
          my_done++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_val = 1'b0; in_a = '0; in_b = '0; src_ready = 1'b1;
    dest_val = 1'b0; product = '0; out_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      in_val = 1'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
      src_ready = 1'($urandom); dest_val = 1'($urandom); product = $urandom; out_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_handshakes", 64'({src_val, dest_ready, out_val, out_err}), 64'd0);
    chk("rst_record", {out_a, out_b, out_p}, 64'd0);
    chk("rst_done", 64'(done_cnt), 64'd0);
    chk("rst_head", 64'({mcand, mplier}), 64'd0);
    @(posedge clk); #1;
    in_val = 1'b0; src_ready = 1'b1; dest_val = 1'b0; product = '0; out_ready = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'({src_val, in_ready, mcand}), {47'd0, 1'b0, 1'b1, 16'd0});
    @(posedge clk); #1;
    in_val = 1'b1; in_a = 16'd3; in_b = 16'hFFFB;
    @(negedge clk);
    chk("single_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_val = 1'b0;
    exp_q.push_back(mk(16'd3, 16'hFFFB, 32'hFFFFFFF1, 1'b0));
    @(negedge clk);
    chk("issue_latency0", 64'(src_val), 64'd0);
    @(negedge clk);
    chk("issue_latency1", 64'({src_val, mcand, mplier}), {31'd0, 1'b1, 16'd3, 16'hFFFB});
    @(negedge clk);
    chk("wait_dest_ready", 64'({src_val, dest_ready}), 64'd1);
    drain("single_drain");
    chk("single_done", 64'(done_cnt), 64'd1);
    for (int i = 0; i < 6; i++) push(va[i], vb[i], vp[i], 1'b0);
    drain("vector_drain");
    src_ready = 1'b0;
    push(16'd1, 16'd2, 32'd2, 1'b0);
    push(16'hFFFE, 16'd3, 32'hFFFFFFFA, 1'b0);
    push(16'd4, 16'hFFFC, 32'hFFFFFFF0, 1'b0);
    push(16'd5, 16'd6, 32'd30, 1'b0);
    in_val = 1'b1; in_a = 16'd9; in_b = 16'd9;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_head", 64'({src_val, mcand, mplier}), {31'd0, 1'b1, 16'd1, 16'd2});
    end
    @(posedge clk); #1;
    in_val = 1'b0; src_ready = 1'b1;
    drain("full_drain");
    out_ready = 1'b0;
    push(16'd10, 16'd20, 32'hC8, 1'b0);
    push(16'hFFFD, 16'd4, 32'hFFFFFFF4, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_val) break;
    end
    chk("bp_out_val", 64'(out_val), 64'd1);
    saved = {out_a, out_b, out_p};
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold", 64'({out_val, dest_ready, src_val}), 64'b100);
      chk("bp_stable", {out_a, out_b, out_p}, saved);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_reissue", 64'({src_val, mcand}), {47'd0, 1'b1, 16'hFFFD});
    drain("bp_drain");
`ifdef BOOTH_MUL_CHECK_EN
    push(16'd7, 16'd7, 32'h0, 1'b1);
`else
    push(16'd7, 16'd7, 32'd49, 1'b0);
`endif
    push(16'd2, 16'd3, 32'd6, 1'b0);
    drain("check_drain");
    push(16'd11, 16'd1, 32'd11, 1'b0);
    push(16'd12, 16'd1, 32'd12, 1'b0);
    push(16'd13, 16'd1, 32'd13, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dest_ready) break;
    end
    chk("rm_in_wait", 64'(dest_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rm_reset_state", 64'({in_ready, src_val, dest_ready, out_val, mcand, mplier}), {28'd0, 4'b1000, 32'd0});
    @(posedge clk); #1;
    rst = 1'b1; my_done = '0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      seen = seen | src_val | dest_ready | out_val;
    end
    chk("rm_quiet", 64'(seen), 64'd0);
    chk("rm_late_dest_ignored", 64'(drops), 64'd1);
    chk("rm_done", 64'(done_cnt), 64'd0);
    @(posedge clk); #1;
    push(16'hFFF9, 16'hFFFA, 32'd42, 1'b0);
    drain("recover_drain");
    chk("recover_done", 64'(done_cnt), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
